// File: rtl/reg_file_dump_if.sv
// Bus bundle for reg_file_dump: two read ports, one write port and the debug dump stream.
// The register file takes the slave modport; the pipeline/debug side takes master.
interface reg_file_dump_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] regS;
   logic [ADDR_W-1:0] regT;
   logic              reS;
   logic              reT;
   logic [DATA_W-1:0] p0;
   logic [DATA_W-1:0] p1;

   logic [ADDR_W-1:0] dst_reg_WB;
   logic [DATA_W-1:0] dst_reg_data_WB;
   logic              we;

   logic              hlt;
   logic              dump_valid;
   logic              dump_ready;
   logic [ADDR_W-1:0] dump_idx;
   logic [DATA_W-1:0] dump_data;
   logic              dump_done;

   modport slave (
      input  regS, regT, reS, reT,
      output p0, p1,
      input  dst_reg_WB, dst_reg_data_WB, we,
      input  hlt, dump_ready,
      output dump_valid, dump_idx, dump_data, dump_done
   );

   modport master (
      output regS, regT, reS, reT,
      input  p0, p1,
      output dst_reg_WB, dst_reg_data_WB, we,
      output hlt, dump_ready,
      input  dump_valid, dump_idx, dump_data, dump_done
   );
endinterface

// File: rtl/reg_file_dump.sv
// Two-read/one-write register file with write-to-read bypass, optional hardwired
// zero register, and a halt-triggered valid/ready dump engine for debug capture.
module reg_file_dump #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   reg_file_dump_if.slave        bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] FIRST_IDX = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
   localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   logic [DATA_W-1:0] p0_q, p0_d;
   logic [DATA_W-1:0] p1_q, p1_d;

   logic              hlt_q, hlt_d;
   state_t            state_q, state_d;
   logic              dump_valid_q, dump_valid_d;
   logic              dump_done_q, dump_done_d;
   logic [ADDR_W-1:0] dump_idx_q, dump_idx_d;

   logic              wr_en;
   logic              start;

   // Writes to register 0 are dropped when it is hardwired, and so is their bypass.
   always_comb begin
      wr_en = bus.we && ((ZERO_REG == 0) || (bus.dst_reg_WB != '0));
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (wr_en) begin
         mem_d[bus.dst_reg_WB] = bus.dst_reg_data_WB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   always_comb begin
      p0_d = p0_q;
      if (bus.reS) begin
         if ((ZERO_REG != 0) && (bus.regS == '0)) begin
            p0_d = '0;
         end else if (wr_en && (bus.dst_reg_WB == bus.regS)) begin
            p0_d = bus.dst_reg_data_WB;
         end else begin
            p0_d = mem_q[bus.regS];
         end
      end
   end

   always_comb begin
      p1_d = p1_q;
      if (bus.reT) begin
         if ((ZERO_REG != 0) && (bus.regT == '0)) begin
            p1_d = '0;
         end else if (wr_en && (bus.dst_reg_WB == bus.regT)) begin
            p1_d = bus.dst_reg_data_WB;
         end else begin
            p1_d = mem_q[bus.regT];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_q <= '0;
         p1_q <= '0;
      end else begin
         p0_q <= p0_d;
         p1_q <= p1_d;
      end
   end

   // hlt_q clears on reset, so a halt already high at release counts as a rising edge.
   always_comb begin
      hlt_d = bus.hlt;
      start = bus.hlt && !hlt_q;
   end

   always_comb begin
      state_d      = state_q;
      dump_valid_d = dump_valid_q;
      dump_done_d  = dump_done_q;
      dump_idx_d   = dump_idx_q;
      case (state_q)
         IDLE: begin
            dump_valid_d = 1'b0;
            dump_done_d  = 1'b0;
            if (start) begin
               state_d      = SEND;
               dump_valid_d = 1'b1;
               dump_idx_d   = FIRST_IDX;
            end
         end
         SEND: begin
            if (dump_valid_q && bus.dump_ready) begin
               if (dump_idx_q == LAST_IDX) begin
                  state_d      = DONE;
                  dump_valid_d = 1'b0;
                  dump_done_d  = 1'b1;
               end else begin
                  dump_idx_d = dump_idx_q + ADDR_W'(1);
               end
            end
         end
         DONE: begin
            if (!bus.hlt) begin
               state_d     = IDLE;
               dump_done_d = 1'b0;
            end
         end
         default: begin
            state_d      = IDLE;
            dump_valid_d = 1'b0;
            dump_done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hlt_q        <= 1'b0;
         state_q      <= IDLE;
         dump_valid_q <= 1'b0;
         dump_done_q  <= 1'b0;
         dump_idx_q   <= '0;
      end else begin
         hlt_q        <= hlt_d;
         state_q      <= state_d;
         dump_valid_q <= dump_valid_d;
         dump_done_q  <= dump_done_d;
         dump_idx_q   <= dump_idx_d;
      end
   end

   // Dump data tracks live storage, so a write to a stalled index shows up immediately.
   assign bus.dump_data  = mem_q[dump_idx_q];
   assign bus.dump_valid = dump_valid_q;
   assign bus.dump_done  = dump_done_q;
   assign bus.dump_idx   = dump_idx_q;
   assign bus.p0         = p0_q;
   assign bus.p1         = p1_q;

endmodule
